// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one single-port data memory between the CPU data port and a
// debug/loader port. CPU wins ties; a starvation counter lets debug win
// after STARVE_MAX denied cycles. dbg_lock drains outstanding reads and then
// hands the memory exclusively to the debug port.
// Optional build macro: DMEM_ARB_STATS_EN adds saturating grant/stall counters.
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
`ifdef DMEM_ARB_STATS_EN
   ,output logic [15:0]   cpu_gnt_cnt,
    output logic [15:0]   dbg_gnt_cnt,
    output logic [15:0]   cpu_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_DRAIN,
        ST_LOCKED
    } state_t;

    localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

    state_t               r_state;
    logic                 r_locked;
    logic [7:0]           r_starve;
    logic [MEM_LAT-1:0]   r_vld;
    logic [MEM_LAT-1:0]   r_own;
    logic [MEM_LAT-1:0]   w_vld_nxt;
    logic [MEM_LAT-1:0]   w_own_nxt;
    logic                 w_cpu_gnt;
    logic                 w_dbg_gnt;

    // Grant selection; reset forces every grant (and so every mem_* output) low at once.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (reset_n) begin
            unique case (r_state)
                ST_ARB: begin
                    if (dbg_req && (r_starve == LP_STARVE_MAX)) begin
                        w_dbg_gnt = 1'b1;
                    end else if (cpu_req) begin
                        w_cpu_gnt = 1'b1;
                    end else if (dbg_req) begin
                        w_dbg_gnt = 1'b1;
                    end
                end
                ST_LOCKED: w_dbg_gnt = dbg_req;
                default: begin
                    w_cpu_gnt = 1'b0;
                    w_dbg_gnt = 1'b0;
                end
            endcase
        end
    end

    // Memory command mux; address and data are zero whenever no access is strobed.
    always_comb begin
        mem_en    = w_cpu_gnt | w_dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Next contents of the read-return pipe: new read enters stage 0, rest shift up.
    always_comb begin
        w_vld_nxt    = '0;
        w_own_nxt    = '0;
        w_vld_nxt[0] = mem_en & ~mem_we;
        w_own_nxt[0] = w_dbg_gnt;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            w_vld_nxt[i] = r_vld[i-1];
            w_own_nxt[i] = r_own[i-1];
        end
    end

    // Read-return pipe of {valid, owner}; owner 1 means the debug port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            r_own <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            r_own <= w_own_nxt;
        end
    end

    // Lock FSM. DRAIN exits once nothing will remain in the pipe after this
    // edge, so LOCKED starts the cycle after the last read returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_ARB;
            r_locked <= 1'b0;
        end else begin
            unique case (r_state)
                ST_ARB: begin
                    if (dbg_lock) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!dbg_lock) begin
                        r_state <= ST_ARB;
                    end else if (~|w_vld_nxt) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!dbg_lock) begin
                        r_state  <= ST_ARB;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_ARB;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Debug starvation counter; saturates because debug always wins at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (w_dbg_gnt || !dbg_req) begin
            r_starve <= '0;
        end else if ((r_state == ST_ARB) && (r_starve != LP_STARVE_MAX)) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign cpu_rvalid = r_vld[MEM_LAT-1] & ~r_own[MEM_LAT-1];
    assign dbg_rvalid = r_vld[MEM_LAT-1] &  r_own[MEM_LAT-1];
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    assign locked     = r_locked;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_cpu_gnt_cnt;
    logic [15:0] r_dbg_gnt_cnt;
    logic [15:0] r_cpu_stall_cnt;

    // Saturating grant and CPU stall counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_gnt_cnt   <= '0;
            r_dbg_gnt_cnt   <= '0;
            r_cpu_stall_cnt <= '0;
        end else begin
            if (w_cpu_gnt && (r_cpu_gnt_cnt != 16'hFFFF)) begin
                r_cpu_gnt_cnt <= r_cpu_gnt_cnt + 16'd1;
            end
            if (w_dbg_gnt && (r_dbg_gnt_cnt != 16'hFFFF)) begin
                r_dbg_gnt_cnt <= r_dbg_gnt_cnt + 16'd1;
            end
            if (cpu_req && !w_cpu_gnt && (r_cpu_stall_cnt != 16'hFFFF)) begin
                r_cpu_stall_cnt <= r_cpu_stall_cnt + 16'd1;
            end
        end
    end

    assign cpu_gnt_cnt   = r_cpu_gnt_cnt;
    assign dbg_gnt_cnt   = r_dbg_gnt_cnt;
    assign cpu_stall_cnt = r_cpu_stall_cnt;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a latency-accurate memory model
// and a read-return scoreboard.
module tb_dmem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we, locked;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   cpu_gnt_cnt, dbg_gnt_cnt, cpu_stall_cnt;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
`ifdef DMEM_ARB_STATS_EN
       ,.cpu_gnt_cnt(cpu_gnt_cnt), .dbg_gnt_cnt(dbg_gnt_cnt), .cpu_stall_cnt(cpu_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          own;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] ref_mem [0:255];
    logic [31:0] mem_arr [0:255];
    logic [31:0] dline   [0:LAT-1];
    bit          mem_init = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears LAT cycles after the strobed cycle.
    assign mem_rdata = dline[LAT-1];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h1000 + 32'(i);
            mem_arr[8] <= 32'h1234;
            for (int i = 0; i < LAT; i++) dline[i] <= 32'hBAD0BAD0;
            mem_init <= 1'b1;
        end else begin
            if (mem_en && mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
            dline[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[7:0]] : 32'hBAD0BAD0;
            for (int i = 1; i < LAT; i++) dline[i] <= dline[i-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic set_cpu(input bit we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input bit we, input logic [31:0] a, input logic [31:0] d);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    // Record an expected grant: writes update the reference, reads queue a return.
    task automatic note(input bit own, input bit we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        if (we) begin
            ref_mem[a[7:0]] = d;
        end else begin
            e.own  = own;
            e.data = ref_mem[a[7:0]];
            e.due  = cyc + LAT;
            sbq.push_back(e);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
        chk({tag, "_dbg_gnt"},    32'(dbg_gnt),    32'd0);
        chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
        chk({tag, "_cpu_rdata"},  cpu_rdata,       32'd0);
        chk({tag, "_dbg_rdata"},  dbg_rdata,       32'd0);
        chk({tag, "_mem_en"},     32'(mem_en),     32'd0);
        chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
        chk({tag, "_mem_addr"},   mem_addr,        32'd0);
        chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        chk({tag, "_locked"},     32'(locked),     32'd0);
    endtask

    // Return monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin : mon
        exp_t e;
        if (cpu_rvalid || dbg_rvalid) begin
            checks++;
            assert (sbq.size() != 0) else begin
                errors++;
                $error("FAIL rv_unexpected observed=cpu%0b/dbg%0b expected=no_rvalid", cpu_rvalid, dbg_rvalid);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("rv_both",  32'(cpu_rvalid & dbg_rvalid), 32'd0);
                chk("rv_owner", 32'(dbg_rvalid), 32'(e.own));
                chk("rv_data",  e.own ? dbg_rdata : cpu_rdata, e.data);
                chk("rv_cycle", 32'(cyc), 32'(e.due));
            end
        end else begin
            chk("rdata_idle", cpu_rdata | dbg_rdata, 32'd0);
            if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                chk("rv_missing", 32'(cpu_rvalid | dbg_rvalid), 32'd1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; dbg_lock = 1'b0;
        idle();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000 + 32'(i);
        ref_mem[8] = 32'h1234;

        // Reset holds every output low even with both ports requesting.
        set_cpu(1'b1, 32'd4, 32'hFF);
        set_dbg(1'b1, 32'd5, 32'hEE);
        @(negedge clk);
        chk_all_zero("rst");
        step(); step();
        idle();
        reset_n = 1'b1;
        step();

        // CPU write with debug idle is granted and driven in the same cycle.
        set_cpu(1'b1, 32'd84, 32'd7);
        @(negedge clk);
        chk("wr_cpu_gnt",   32'(cpu_gnt),  32'd1);
        chk("wr_dbg_gnt",   32'(dbg_gnt),  32'd0);
        chk("wr_mem_en",    32'(mem_en),   32'd1);
        chk("wr_mem_we",    32'(mem_we),   32'd1);
        chk("wr_mem_addr",  mem_addr,      32'd84);
        chk("wr_mem_wdata", mem_wdata,     32'd7);
        note(1'b0, 1'b1, 32'd84, 32'd7);
        step();

        // Debug reads the word back.
        idle();
        set_dbg(1'b0, 32'd84, 32'd0);
        @(negedge clk);
        chk("rd_dbg_gnt",  32'(dbg_gnt), 32'd1);
        chk("rd_mem_addr", mem_addr,     32'd84);
        note(1'b1, 1'b0, 32'd84, 32'd0);
        step();

        // CPU read of address 8 returns 0x1234 after LAT cycles.
        idle();
        set_cpu(1'b0, 32'd8, 32'd0);
        @(negedge clk);
        chk("rd8_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd8_mem_we",  32'(mem_we),  32'd0);
        note(1'b0, 1'b0, 32'd8, 32'd0);
        step();
        idle();
        for (int i = 0; i <= LAT; i++) step();
        chk("rd8_drained", 32'(sbq.size()), 32'd0);

        // Alternating owners, back to back, no bubbles.
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k % 2 == 0) set_cpu(1'b0, 32'(16 + k), 32'd0);
            else            set_dbg(1'b0, 32'(16 + k), 32'd0);
            @(negedge clk);
            chk("alt_gnt", 32'((k % 2 == 0) ? cpu_gnt : dbg_gnt), 32'd1);
            note(k % 2 == 1, 1'b0, 32'(16 + k), 32'd0);
            step();
        end

        // Write then read of the same address on consecutive grants.
        idle();
        set_cpu(1'b1, 32'd40, 32'hAA);
        @(negedge clk);
        chk("raw_wr_gnt", 32'(cpu_gnt), 32'd1);
        note(1'b0, 1'b1, 32'd40, 32'hAA);
        step();
        idle();
        set_dbg(1'b0, 32'd40, 32'd0);
        @(negedge clk);
        chk("raw_rd_gnt", 32'(dbg_gnt), 32'd1);
        note(1'b1, 1'b0, 32'd40, 32'd0);
        step();
        idle();
        for (int i = 0; i <= LAT; i++) step();

        // Both ports hold requests: 8 CPU grants then one debug grant, repeating.
        for (int k = 0; k < 27; k++) begin
            bit e;
            e = (k % 9 == 8);
            set_cpu(1'b1, 32'd100, 32'(k));
            set_dbg(1'b1, 32'd101, 32'h100 + 32'(k));
            @(negedge clk);
            chk("starve_dbg_gnt", 32'(dbg_gnt), 32'(e));
            chk("starve_cpu_gnt", 32'(cpu_gnt), 32'(!e));
            if (e) note(1'b1, 1'b1, 32'd101, 32'h100 + 32'(k));
            else   note(1'b0, 1'b1, 32'd100, 32'(k));
            step();
        end
        idle();
        step();

        // Lock: drain the in-flight CPU read, then CPU is shut out until unlock.
        set_cpu(1'b0, 32'd8, 32'd0);
        @(negedge clk);
        chk("lk_rd_gnt", 32'(cpu_gnt), 32'd1);
        note(1'b0, 1'b0, 32'd8, 32'd0);
        step();
        idle();
        dbg_lock = 1'b1;
        @(negedge clk);
        chk("lk_arb_locked", 32'(locked), 32'd0);
        chk("lk_arb_mem_en", 32'(mem_en), 32'd0);
        step();
        set_cpu(1'b1, 32'd120, 32'h55);
        @(negedge clk);
        chk("lk_drain_locked",  32'(locked),  32'd0);
        chk("lk_drain_cpu_gnt", 32'(cpu_gnt), 32'd0);
        step();
        for (int j = 0; j < 4; j++) begin
            dbg_req = 1'b0;
            if (j == 1) set_dbg(1'b1, 32'd121, 32'h66);
            if (j == 3) dbg_lock = 1'b0;
            @(negedge clk);
            chk("lk_locked",  32'(locked),  32'd1);
            chk("lk_cpu_gnt", 32'(cpu_gnt), 32'd0);
            if (j == 1) begin
                chk("lk_dbg_gnt", 32'(dbg_gnt), 32'd1);
                note(1'b1, 1'b1, 32'd121, 32'h66);
            end
            step();
        end
        dbg_req = 1'b0;
        @(negedge clk);
        chk("unlk_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("unlk_locked",  32'(locked),  32'd0);
        note(1'b0, 1'b1, 32'd120, 32'h55);
        step();
        idle();
        set_cpu(1'b0, 32'd121, 32'd0);
        @(negedge clk);
        chk("lk_verify_gnt", 32'(cpu_gnt), 32'd1);
        note(1'b0, 1'b0, 32'd121, 32'd0);
        step();
        idle();
        for (int i = 0; i <= LAT; i++) step();

        // Reset one cycle after a read grant drops the read.
        set_cpu(1'b0, 32'd30, 32'd0);
        @(negedge clk);
        chk("rr_gnt", 32'(cpu_gnt), 32'd1);
        step();
        reset_n = 1'b0;
        set_cpu(1'b1, 32'd50, 32'h77);
        set_dbg(1'b1, 32'd51, 32'h88);
        #1;
        chk_all_zero("rst_mid");
        step(); step();
        idle();
        reset_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) step();
        chk("rr_locked", 32'(locked), 32'd0);

`ifdef DMEM_ARB_STATS_EN
        chk("st_cpu0",   32'(cpu_gnt_cnt),   32'd0);
        chk("st_dbg0",   32'(dbg_gnt_cnt),   32'd0);
        chk("st_stall0", 32'(cpu_stall_cnt), 32'd0);
        dbg_lock = 1'b1;
        step(); step();
        for (int k = 0; k < 3; k++) begin
            idle();
            if (k < 2) set_cpu(1'b1, 32'd200, 32'(k));
            set_dbg(1'b1, 32'd201, 32'(k));
            @(negedge clk);
            chk("st_dbg_gnt", 32'(dbg_gnt), 32'd1);
            note(1'b1, 1'b1, 32'd201, 32'(k));
            step();
        end
        idle();
        dbg_lock = 1'b0;
        step(); step();
        for (int k = 0; k < 10; k++) begin
            set_cpu(1'b1, 32'd202, 32'(k));
            @(negedge clk);
            chk("st_cpu_gnt", 32'(cpu_gnt), 32'd1);
            note(1'b0, 1'b1, 32'd202, 32'(k));
            step();
        end
        idle();
        step();
        chk("st_cpu_cnt",   32'(cpu_gnt_cnt),   32'd10);
        chk("st_dbg_cnt",   32'(dbg_gnt_cnt),   32'd3);
        chk("st_stall_cnt", 32'(cpu_stall_cnt), 32'd2);
`endif

        idle();
        for (int i = 0; i < LAT + 2; i++) step();
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
